// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-adder result consumer.
// Holds the accumulator FSM state encoding, default parameter values and
// the width of one adder result ({cout, sum[3:0]}).
package adder_pkg;

  typedef enum logic {
    ST_ACCUM,
    ST_HOLD
  } state_e;

  localparam int unsigned ACC_W_DEF   = 8;
  localparam int unsigned COUNT_N_DEF = 4;
  localparam int unsigned RES_W       = 5;

endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT_N adder results into a batch total.
//
// Each accepted beat adds the zero-extended 5-bit {in_cout, in_sum} into a
// running ACC_W-bit total. After COUNT_N beats the total is offered on a
// valid/ready port and held until taken; out_ovf is set if the total wrapped
// at any point during the batch.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   beat present on in_sum/in_cout
//   in_ready   block accepts a beat (ACCUM state)
//   in_sum     4-bit sum from the adder
//   in_cout    carry-out from the adder
//   clr        synchronous abort, discards the current batch
//   out_valid  batch total available (HOLD state)
//   out_ready  downstream takes the total
//   out_acc    batch total modulo 2^ACC_W
//   out_ovf    sticky wrap flag for this batch
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned COUNT_N = COUNT_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CntW = $clog2(COUNT_N + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT_N - 1);

  if (ACC_W < RES_W) begin : g_bad_acc_w
    $error("ACC_W must be at least RES_W");
  end
  if (COUNT_N < 1) begin : g_bad_count_n
    $error("COUNT_N must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [RES_W-1:0]  addend;
  logic [ACC_W:0]    sum_full;  // MSB is the carry out of the accumulator
  logic              accept;

  assign addend   = {in_cout, in_sum};
  assign sum_full = {1'b0, acc_q} + {1'b0, ACC_W'(addend)};

  // Handshake outputs depend on state only.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

  assign accept = in_ready & in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      // Abort wins over any beat or handshake in the same cycle.
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_d = sum_full[ACC_W-1:0];
            ovf_d = ovf_q | sum_full[ACC_W];
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: three instances (defaults, ACC_W=6,
// COUNT_N=1) share data/control inputs; sel routes valid/ready/clr to one.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_cout, clr, out_ready;
  logic [3:0] in_sum;
  logic [1:0] sel;

  logic [2:0] rdy, vld, ovf;
  logic [7:0] acc0, acc2;
  logic [5:0] acc1;

  logic       cur_rdy, cur_vld, cur_ovf;
  logic [7:0] cur_acc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sum_accumulator u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel == 2'd0),
    .in_ready  (rdy[0]),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .clr       (clr && sel == 2'd0),
    .out_valid (vld[0]),
    .out_ready (out_ready && sel == 2'd0),
    .out_acc   (acc0),
    .out_ovf   (ovf[0])
  );

  sum_accumulator #(.ACC_W(6), .COUNT_N(4)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel == 2'd1),
    .in_ready  (rdy[1]),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .clr       (clr && sel == 2'd1),
    .out_valid (vld[1]),
    .out_ready (out_ready && sel == 2'd1),
    .out_acc   (acc1),
    .out_ovf   (ovf[1])
  );

  sum_accumulator #(.ACC_W(8), .COUNT_N(1)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel == 2'd2),
    .in_ready  (rdy[2]),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .clr       (clr && sel == 2'd2),
    .out_valid (vld[2]),
    .out_ready (out_ready && sel == 2'd2),
    .out_acc   (acc2),
    .out_ovf   (ovf[2])
  );

  always_comb begin
    cur_rdy = rdy[0];
    cur_vld = vld[0];
    cur_ovf = ovf[0];
    cur_acc = acc0;
    if (sel == 2'd1) begin
      cur_rdy = rdy[1];
      cur_vld = vld[1];
      cur_ovf = ovf[1];
      cur_acc = {2'b00, acc1};
    end else if (sel == 2'd2) begin
      cur_rdy = rdy[2];
      cur_vld = vld[2];
      cur_ovf = ovf[2];
      cur_acc = acc2;
    end
  end

  typedef struct {
    logic [1:0]      sel;
    int              nb;
    logic [3:0][4:0] beats;  // beats[0] is applied first
    int              gap;
    logic [7:0]      acc;
    logic            ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Apply the beats of one vector and check the HOLD state that follows.
  task automatic load(input vec_t v, input string tag);
    sel = v.sel;
    for (int i = 0; i < v.nb; i++) begin
      in_valid = 1'b1;
      {in_cout, in_sum} = v.beats[i];
      tick();
      in_valid = 1'b0;
      if (i < v.nb - 1) begin
        chk({tag, " mid out_valid"}, 32'(cur_vld), 32'd0);
        repeat (v.gap) tick();
      end
    end
    chk({tag, " out_valid"}, 32'(cur_vld), 32'd1);
    chk({tag, " in_ready"},  32'(cur_rdy), 32'd0);
    chk({tag, " out_acc"},   32'(cur_acc), 32'(v.acc));
    chk({tag, " out_ovf"},   32'(cur_ovf), 32'(v.ovf));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " post out_valid"}, 32'(cur_vld), 32'd0);
    chk({tag, " post in_ready"},  32'(cur_rdy), 32'd1);
    chk({tag, " post out_acc"},   32'(cur_acc), 32'd0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 4, {5'b01111, 5'b01010, 5'b10000, 5'b00000}, 0, 8'h29, 1'b0};
    tbl[1] = '{2'd0, 4, {5'b01111, 5'b01010, 5'b10000, 5'b00000}, 2, 8'h29, 1'b0};
    tbl[2] = '{2'd1, 4, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, 0, 8'd60, 1'b1};
    tbl[3] = '{2'd1, 4, {5'b00001, 5'b00001, 5'b00001, 5'b00001}, 0, 8'd4, 1'b0};
    tbl[4] = '{2'd2, 1, {5'b00000, 5'b00000, 5'b00000, 5'b00011}, 0, 8'd3, 1'b0};
    tbl[5] = '{2'd0, 4, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, 1, 8'h7c, 1'b0};
    tbl[6] = '{2'd1, 4, {5'b11111, 5'b11111, 5'b11111, 5'b00001}, 3, 8'd30, 1'b1};
    tbl[7] = '{2'd2, 1, {5'b00000, 5'b00000, 5'b00000, 5'b11111}, 0, 8'd31, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_cout = 1'b0; in_sum = 4'd0;
    clr = 1'b0; out_ready = 1'b0; sel = 2'd0;
    tick(); tick();
    chk("rst in_ready",  32'(cur_rdy), 32'd1);
    chk("rst out_valid", 32'(cur_vld), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel in_ready",  32'(cur_rdy), 32'd1);
    chk("rel out_valid", 32'(cur_vld), 32'd0);
    chk("rel out_acc",   32'(cur_acc), 32'd0);
    chk("rel out_ovf",   32'(cur_ovf), 32'd0);

    foreach (tbl[k]) begin
      load(tbl[k], $sformatf("vec%0d", k));
      take($sformatf("vec%0d", k));
    end

    // Backpressure: total held, offered beats ignored while in HOLD.
    load(tbl[0], "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      {in_cout, in_sum} = 5'b11111;
      tick();
      chk("bp hold acc",   32'(cur_acc), 32'h29);
      chk("bp hold valid", 32'(cur_vld), 32'd1);
    end
    in_valid = 1'b0;
    take("bp");

    // clr with a beat offered in the same cycle: beat dropped, batch restarts.
    sel = 2'd0;
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd5; tick();
    {in_cout, in_sum} = 5'd7; tick();
    chk("clr pre acc", 32'(cur_acc), 32'd12);
    clr = 1'b1;
    {in_cout, in_sum} = 5'd9; tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr acc",   32'(cur_acc), 32'd0);
    chk("clr valid", 32'(cur_vld), 32'd0);
    tbl[0] = '{2'd0, 4, {5'd1, 5'd1, 5'd1, 5'd1}, 0, 8'd4, 1'b0};
    load(tbl[0], "clr batch");
    // clr in HOLD consumes the output.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr hold valid", 32'(cur_vld), 32'd0);
    chk("clr hold ready", 32'(cur_rdy), 32'd1);
    chk("clr hold acc",   32'(cur_acc), 32'd0);

    // Asynchronous reset mid-batch, away from any clock edge.
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd5; tick(); tick();
    in_valid = 1'b0;
    chk("arst pre acc", 32'(cur_acc), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("arst acc",   32'(cur_acc), 32'd0);
    chk("arst ready", 32'(cur_rdy), 32'd1);
    chk("arst valid", 32'(cur_vld), 32'd0);
    tick();
    rst = 1'b0;
    // Async reset while holding a total.
    tbl[0] = '{2'd0, 4, {5'd2, 5'd2, 5'd2, 5'd2}, 0, 8'd8, 1'b0};
    load(tbl[0], "arst hold");
    #2 rst = 1'b1;
    #1;
    chk("arst hold valid", 32'(cur_vld), 32'd0);
    chk("arst hold acc",   32'(cur_acc), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
